// File: rtl/lenet_pkg.sv
// Shared LeNet constants: conv1 weight ROM geometry and the weight-fetch FSM encoding.
package lenet_pkg;

    localparam int WT_W          = 8;
    localparam int N_CH1         = 6;
    localparam int W1_ADDR_W     = 5;
    localparam int W1_DATA_W     = WT_W * N_CH1;
    localparam int W1_WORDS      = 25;
    localparam int W1_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } w1_state_t;

endpackage

// File: rtl/w1_wt_fifo.sv
// Small synchronous FIFO holding weight words with their kernel-position tag.
// A push is accepted while full when a pop happens in the same cycle.
module w1_wt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 53
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & ((count != CNT_W'(DEPTH)) | rd_en);
    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // Storage array write port.
    // NOTE: the array has no reset; occupancy is tracked by count, so stale entries are never read out.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/w1_fetch_ctrl.sv
// Conv1 weight-ROM sequencer: sweeps addresses 0..N_WORDS-1, absorbs the ROM's
// registered read latency through a 2-stage in-flight tag pipeline, and buffers
// words in a credit-controlled FIFO so downstream back-pressure never loses data.
module w1_fetch_ctrl
    import lenet_pkg::*;
#(
    parameter int ADDR_W     = W1_ADDR_W,
    parameter int DATA_W     = W1_DATA_W,
    parameter int N_WORDS    = W1_WORDS,
    parameter int FIFO_DEPTH = W1_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] w1_raddr,
    input  logic [DATA_W-1:0] w1_rdata,
    output logic              wt_valid,
    input  logic              wt_ready,
    output logic [DATA_W-1:0] wt_data,
    output logic [ADDR_W-1:0] wt_idx,
    output logic              wt_last
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    w1_state_t          state;
    w1_state_t          state_nxt;
    logic [ADDR_W-1:0]  next_addr;
    logic               issue;
    logic               pop;
    logic               credit_ok;
    logic [CNT_W:0]     credit_used;

    // In-flight pipeline: s0 = address register stage, s1 = ROM output stage.
    logic               s0_vld;
    logic               s1_vld;
    logic [ADDR_W-1:0]  s1_idx;

    logic [CNT_W-1:0]       fifo_cnt;
    logic                   fifo_empty;
    logic [DATA_W+ADDR_W-1:0] fifo_rdata;

    assign wt_valid = ~fifo_empty;
    assign pop      = wt_valid & wt_ready;
    assign wt_data  = wt_valid ? fifo_rdata[DATA_W+ADDR_W-1:ADDR_W] : '0;
    assign wt_idx   = wt_valid ? fifo_rdata[ADDR_W-1:0] : '0;
    assign wt_last  = wt_valid & (wt_idx == LAST_ADDR);
    assign busy     = (state == ST_FETCH) | (state == ST_DRAIN);
    assign done     = (state == ST_DONE);

    // Credit: words buffered plus words in flight, minus the word leaving this cycle.
    assign credit_used = (CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(s0_vld)
                       + (CNT_W+1)'(s1_vld) - (CNT_W+1)'(pop);
    assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and issue decision.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    issue     = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (next_addr == LAST_ADDR) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && wt_last) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ROM address register and sequential address counter; address holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w1_raddr  <= '0;
            next_addr <= '0;
        end else if (issue) begin
            w1_raddr  <= next_addr;
            next_addr <= (next_addr == LAST_ADDR) ? '0 : next_addr + ADDR_W'(1);
        end
    end

    // In-flight tags that track each issued address through the ROM's read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld <= 1'b0;
            s1_vld <= 1'b0;
            s1_idx <= '0;
        end else begin
            s0_vld <= issue;
            s1_vld <= s0_vld;
            s1_idx <= w1_raddr;
        end
    end

    w1_wt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_vld),
        .wdata ({w1_rdata, s1_idx}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_w1_fetch_ctrl.sv
// Self-checking bench for w1_fetch_ctrl: registered ROM model, stream scoreboard,
// directed timing checks and randomized back-pressure.
module tb_w1_fetch_ctrl;
    import lenet_pkg::*;

    localparam int AW = W1_ADDR_W;
    localparam int DW = W1_DATA_W;
    localparam int NW = W1_WORDS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] w1_raddr;
    logic [DW-1:0] w1_rdata = '0;
    logic          wt_valid;
    logic          wt_ready = 1'b1;
    logic [DW-1:0] wt_data;
    logic [AW-1:0] wt_idx;
    logic          wt_last;

    int n_checks = 0;
    int n_bad    = 0;
    int n_done   = 0;

    w1_fetch_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .w1_raddr (w1_raddr),
        .w1_rdata (w1_rdata),
        .wt_valid (wt_valid),
        .wt_ready (wt_ready),
        .wt_data  (wt_data),
        .wt_idx   (wt_idx),
        .wt_last  (wt_last)
    );

    always #5 clk = ~clk;

    // Weight word for kernel position a: byte k = a + k.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int k = 0; k < N_CH1; k++) w[WT_W*k +: WT_W] = 8'(a) + 8'(k);
        return w;
    endfunction

    // ROM model with one cycle of registered read latency.
    always @(posedge clk) w1_rdata <= rom_word(w1_raddr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every sweep must deliver idx 0..NW-1 in order, stable under stall,
    // followed by exactly one done pulse in the cycle after the last transfer.
    int            exp_idx  = 0;
    int            hs_cnt   = 0;
    logic          done_due = 1'b0;
    logic          stalled  = 1'b0;
    logic [63:0]   held     = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_idx  = 0;
            hs_cnt   = 0;
            done_due = 1'b0;
            stalled  = 1'b0;
        end else begin
            check("done_pulse", 64'(done), 64'(done_due));
            if (done) begin
                check("sweep_len", 64'(hs_cnt), 64'(NW));
                hs_cnt = 0;
                n_done++;
            end
            if (stalled) begin
                check("hold_valid", 64'(wt_valid), 64'd1);
                check("hold_payload", 64'({wt_data, wt_idx, wt_last}), held);
            end
            done_due = 1'b0;
            if (wt_valid && wt_ready) begin
                check("idx", 64'(wt_idx), 64'(exp_idx));
                check("data", 64'(wt_data), 64'(rom_word(AW'(exp_idx))));
                check("last", 64'(wt_last), 64'(exp_idx == NW - 1));
                hs_cnt++;
                if (exp_idx == NW - 1) begin
                    exp_idx  = 0;
                    done_due = 1'b1;
                end else begin
                    exp_idx++;
                end
            end
            stalled = wt_valid && !wt_ready;
            held    = 64'({wt_data, wt_idx, wt_last});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advance until done is seen (left in the DONE cycle); optional random ready.
    task automatic wait_done(input int max_cycles, input bit rand_ready);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            if (rand_ready) wt_ready = 1'($urandom % 2);
            tick();
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        wt_ready = 1'b1;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(wt_valid), 64'd0);
        check("rst_raddr", 64'(w1_raddr), 64'd0);
        check("rst_outs", 64'({wt_data, wt_idx, wt_last}), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: full-rate sweep, cycle-exact timing
        wt_ready = 1'b1;
        pulse_start();
        check("t1_busy0", 64'(busy), 64'd1);
        check("t1_raddr0", 64'(w1_raddr), 64'd0);
        check("t1_valid0", 64'(wt_valid), 64'd0);
        tick();
        check("t1_raddr1", 64'(w1_raddr), 64'd1);
        check("t1_valid1", 64'(wt_valid), 64'd0);
        for (int k = 0; k < NW; k++) begin
            tick();
            check("t1_valid", 64'(wt_valid), 64'd1);
            check("t1_idx", 64'(wt_idx), 64'(k));
            check("t1_busy", 64'(busy), 64'd1);
        end
        tick();
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy_done", 64'(busy), 64'd0);
        check("t1_valid_done", 64'(wt_valid), 64'd0);
        tick();
        check("t1_done_clr", 64'(done), 64'd0);
        check("t1_raddr_end", 64'(w1_raddr), 64'(NW - 1));

        // 2: back-pressure right after start, buffer fills to depth
        wt_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 9; i++) tick();
        check("t2_raddr_stop", 64'(w1_raddr), 64'd3);
        check("t2_valid", 64'(wt_valid), 64'd1);
        check("t2_idx0", 64'(wt_idx), 64'd0);
        wt_ready = 1'b1;
        wait_done(200, 1'b0);
        tick();

        // 3: random ready over many sweeps
        for (int s = 0; s < 20; s++) begin
            pulse_start();
            wait_done(1000, 1'b1);
            tick();
        end
        check("t3_done_cnt", 64'(n_done), 64'd22);

        // 4: starts while busy and in DONE are ignored; start in first IDLE cycle is taken
        wt_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        pulse_start();
        check("t4_busy_e5", 64'(busy), 64'd1);
        wait_done(200, 1'b0);
        check("t4_in_done", 64'(done), 64'd1);
        pulse_start();
        check("t4_ign_busy", 64'(busy), 64'd0);
        check("t4_raddr_hold", 64'(w1_raddr), 64'(NW - 1));
        pulse_start();
        check("t4_restart_busy", 64'(busy), 64'd1);
        check("t4_restart_raddr", 64'(w1_raddr), 64'd0);
        wait_done(200, 1'b0);
        tick();
        check("t4_done_cnt", 64'(n_done), 64'd24);

        // 5: reset mid-stream aborts silently
        pulse_start();
        for (int i = 0; i < 11; i++) tick();
        rst = 1'b1;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_valid", 64'(wt_valid), 64'd0);
        check("t5_raddr", 64'(w1_raddr), 64'd0);
        check("t5_outs", 64'({wt_data, wt_idx, wt_last}), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t5_no_done_cnt", 64'(n_done), 64'd24);
        pulse_start();
        wait_done(200, 1'b0);
        tick();
        tick();
        check("final_done_cnt", 64'(n_done), 64'd25);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
